// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command sequencer.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_RESP,
    ST_RD_FETCH,
    ST_RD_WAIT,
    ST_RD_SEND
  } cmd_state_t;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_JOY   = 8'h03;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK_DEFAULT  = 8'h5A;
  localparam logic [7:0] NAK_DEFAULT  = 8'hEE;

  // Increment that sticks at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream (RX/TX) and program-RAM bus bundle for the command sequencer.
interface uart_cmd_ctrl_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  // Sequencer side: consumes RX and memory read data, drives TX and memory.
  modport master (
    input  rx_byte, rx_valid, tx_ready, mem_rdata,
    output tx_byte, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
  );

  // Environment side: UART receiver/transmitter and the RAM.
  modport slave (
    output rx_byte, rx_valid, tx_ready, mem_rdata,
    input  tx_byte, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle watchdog: reloadable down-counter that flags expiry.
module uart_cmd_timeout #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;

  // Reload on every byte (or while disabled), otherwise count idle cycles down to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= LOAD_VAL;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host packet parser / sequencer between the UART byte channel, program RAM and joypad.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         CLK_HZ         = 21477000,
  // ~100 ms of clock cycles, rounded up to a multiple of 1000
  parameter int         TIMEOUT_CYCLES = ((CLK_HZ + 9999) / 10000) * 1000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_cmd_ctrl_if.master  bus,
  output logic [7:0]       joy_state,
  output logic             busy,
  output logic [7:0]       err_count
);

  cmd_state_t  state_q;
  logic [7:0]  cmd_q;
  logic [15:0] addr_q;
  logic [8:0]  cnt_q;
  logic [7:0]  sum_q;
  logic [7:0]  joy_shadow_q;
  logic [7:0]  joy_q;
  logic [7:0]  err_q;
  logic        rd_ok_q;
  logic [7:0]  tx_byte_q;
  logic        tx_valid_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        mem_we_q;
  logic        mem_re_q;

  logic [7:0]  sum_d;
  logic        cmd_known;
  logic        rx_phase;
  logic        tmo_expired;

  assign sum_d     = sum_q + bus.rx_byte;
  assign cmd_known = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ) || (cmd_q == CMD_JOY);
  // Only the packet-receiving states are subject to the inter-byte timeout.
  assign rx_phase  = (state_q == ST_CMD)    || (state_q == ST_ADDR_H)  ||
                     (state_q == ST_ADDR_L) || (state_q == ST_LEN)     ||
                     (state_q == ST_PAYLOAD)|| (state_q == ST_CSUM);

  uart_cmd_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (bus.rx_valid || !rx_phase),
    .en_i      (rx_phase),
    .expired_o (tmo_expired)
  );

  // Main sequencer: packet parse, streamed writes, response and read-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 8'h00;
      addr_q       <= 16'h0000;
      cnt_q        <= 9'd0;
      sum_q        <= 8'h00;
      joy_shadow_q <= 8'h00;
      joy_q        <= 8'h00;
      err_q        <= 8'h00;
      rd_ok_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 8'h00;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.rx_valid && (bus.rx_byte == SYNC_BYTE)) state_q <= ST_CMD;
        end
        ST_CMD: begin
          if (bus.rx_valid) begin
            cmd_q   <= bus.rx_byte;
            sum_q   <= bus.rx_byte;
            state_q <= ST_ADDR_H;
          end
        end
        ST_ADDR_H: begin
          if (bus.rx_valid) begin
            addr_q[15:8] <= bus.rx_byte;
            sum_q        <= sum_d;
            state_q      <= ST_ADDR_L;
          end
        end
        ST_ADDR_L: begin
          if (bus.rx_valid) begin
            addr_q[7:0] <= bus.rx_byte;
            sum_q       <= sum_d;
            state_q     <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (bus.rx_valid) begin
            sum_q <= sum_d;
            // JOY always carries exactly one payload byte regardless of LEN
            cnt_q <= (cmd_q == CMD_JOY) ? 9'd1 : {1'b0, bus.rx_byte} + 9'd1;
            state_q <= ((cmd_q == CMD_WRITE) || (cmd_q == CMD_JOY)) ? ST_PAYLOAD : ST_CSUM;
          end
        end
        ST_PAYLOAD: begin
          if (bus.rx_valid) begin
            sum_q <= sum_d;
            if (cmd_q == CMD_WRITE) begin
              // Written immediately; a later checksum failure does not undo it
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= bus.rx_byte;
              addr_q      <= addr_q + 16'd1;
            end else begin
              joy_shadow_q <= bus.rx_byte;
            end
            cnt_q <= cnt_q - 9'd1;
            if (cnt_q == 9'd1) state_q <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (bus.rx_valid) begin
            tx_valid_q <= 1'b1;
            state_q    <= ST_RESP;
            if ((bus.rx_byte == sum_q) && cmd_known) begin
              tx_byte_q <= ACK_BYTE;
              rd_ok_q   <= (cmd_q == CMD_READ);
              if (cmd_q == CMD_JOY) joy_q <= joy_shadow_q;
            end else begin
              tx_byte_q <= NAK_BYTE;
              rd_ok_q   <= 1'b0;
              err_q     <= sat_inc8(err_q);
            end
          end
        end
        ST_RESP: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            if (rd_ok_q) begin
              // mem_re is visible during RD_FETCH, data arrives during RD_WAIT
              mem_re_q   <= 1'b1;
              mem_addr_q <= addr_q;
              state_q    <= ST_RD_FETCH;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_RD_FETCH: begin
          state_q <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          tx_byte_q  <= bus.mem_rdata;
          tx_valid_q <= 1'b1;
          state_q    <= ST_RD_SEND;
        end
        ST_RD_SEND: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            addr_q     <= addr_q + 16'd1;
            cnt_q      <= cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
              state_q <= ST_IDLE;
            end else begin
              mem_re_q   <= 1'b1;
              mem_addr_q <= addr_q + 16'd1;
              state_q    <= ST_RD_FETCH;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Abandon a stalled packet silently; only the error counter records it
      if (tmo_expired) begin
        state_q <= ST_IDLE;
        err_q   <= sat_inc8(err_q);
      end
    end
  end

  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign joy_state     = joy_q;
  assign err_count     = err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
